// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
// Glyphs are active-high, bit order {dp,g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_e;

    // Index 0 is the rightmost entry of the concatenation.
    localparam logic [15:0][7:0] GLYPH = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

    function automatic logic [7:0] seg_off(input bit active_low);
        return active_low ? 8'hFF : 8'h00;
    endfunction

    function automatic logic [7:0] seg_on(input logic [7:0] lit, input bit active_low);
        return active_low ? ~lit : lit;
    endfunction

endpackage

// File: rtl/seg7_scan_n_if.sv
// Datapath-side and pin-side signals of the scanner; master drives the digits,
// slave is the scanner itself.
interface seg7_scan_n_if #(
    parameter int NDIG = 4
);
    logic [4*NDIG-1:0] DATA;
    logic [NDIG-1:0]   DP_EN;
    logic [NDIG-1:0]   DIG_EN;
    logic              LZB;
    logic [3:0]        BRIGHT;
    logic [7:0]        PATTERN;
    logic [NDIG-1:0]   DIGIT;
    logic              FRAME;

    modport master (
        output DATA, DP_EN, DIG_EN, LZB, BRIGHT,
        input  PATTERN, DIGIT, FRAME
    );

    modport slave (
        input  DATA, DP_EN, DIG_EN, LZB, BRIGHT,
        output PATTERN, DIGIT, FRAME
    );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-high {g..a} glyph; polarity is applied by the caller.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH[nibble][6:0];
    end

endmodule

// File: rtl/seg7_scan_n.sv
// Time-multiplexed NDIG-digit hex display driver with dark gaps, PWM dimming,
// leading-zero blanking and a per-frame snapshot of the display inputs.
module seg7_scan_n
    import seg7_pkg::*;
#(
    parameter int NDIG           = 4,
    parameter int SLOT_CYCLES    = 50000,
    parameter int BLANK_CYCLES   = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input logic         CLK,
    input logic         IN_CLR,
    seg7_scan_n_if.slave bus
);

    localparam int CMAX = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(CMAX);
    localparam int IW   = $clog2(NDIG);

    localparam logic [CW-1:0]   SLOT_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0]   BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0]   IDX_LAST   = IW'(NDIG - 1);
    localparam logic [NDIG-1:0] DIG_NONE   = {NDIG{DIG_ACTIVE_LOW}};
    localparam logic [7:0]      PAT_OFF    = seg_off(SEG_ACTIVE_LOW);

    state_e                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             pwm_q, pwm_d;

    logic [NDIG-1:0][3:0]   data_sh_q, data_sh_d;
    logic [NDIG-1:0]        dp_sh_q, dp_sh_d;
    logic [NDIG-1:0]        en_sh_q, en_sh_d;
    logic                   lzb_sh_q, lzb_sh_d;

    logic [7:0]             pattern_q, pattern_d;
    logic [NDIG-1:0]        digit_q, digit_d;
    logic                   frame_arm_q, frame_arm_d;
    logic                   frame_q;

    logic                   snap;
    logic [3:0]             nib;
    logic [6:0]             glyph;
    logic [NDIG-1:0]        lz_blank;
    logic                   zero_run;
    logic [7:0]             lit;

    // Scan sequencer: BLANK then SHOW per digit, timing independent of content.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q + CW'(1);
        pwm_d       = pwm_q + 4'd1;
        snap        = 1'b0;
        frame_arm_d = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                    pwm_d   = '0;
                    snap    = (idx_q == '0);
                end
            end
            ST_SHOW: begin
                if (cnt_q == SLOT_LAST) begin
                    state_d     = ST_BLANK;
                    cnt_d       = '0;
                    idx_d       = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
                    frame_arm_d = (idx_q == IDX_LAST);
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        data_sh_d = data_sh_q;
        dp_sh_d   = dp_sh_q;
        en_sh_d   = en_sh_q;
        lzb_sh_d  = lzb_sh_q;
        if (snap) begin
            data_sh_d = bus.DATA;
            dp_sh_d   = bus.DP_EN;
            en_sh_d   = bus.DIG_EN;
            lzb_sh_d  = bus.LZB;
        end
    end

    // A digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        zero_run = 1'b1;
        lz_blank = '0;
        for (int i = NDIG - 1; i >= 1; i--) begin
            zero_run    = zero_run & (data_sh_q[i] == 4'h0);
            lz_blank[i] = lzb_sh_q & zero_run;
        end
    end

    assign nib = data_sh_q[idx_q];

    seg7_hex_decode u_dec (
        .nibble (nib),
        .glyph  (glyph)
    );

    always_comb begin
        lit       = {dp_sh_q[idx_q], lz_blank[idx_q] ? 7'h00 : glyph};
        pattern_d = PAT_OFF;
        digit_d   = DIG_NONE;
        if (state_q == ST_SHOW && en_sh_q[idx_q]) begin
            digit_d = DIG_NONE ^ (NDIG'(1) << idx_q);
            if (pwm_q <= bus.BRIGHT) begin
                pattern_d = seg_on(lit, SEG_ACTIVE_LOW);
            end
        end
    end

    always_ff @(posedge CLK or negedge IN_CLR) begin
        if (!IN_CLR) begin
            state_q     <= ST_BLANK;
            idx_q       <= '0;
            cnt_q       <= '0;
            pwm_q       <= '0;
            data_sh_q   <= '0;
            dp_sh_q     <= '0;
            en_sh_q     <= '0;
            lzb_sh_q    <= 1'b0;
            pattern_q   <= PAT_OFF;
            digit_q     <= DIG_NONE;
            frame_arm_q <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            pwm_q       <= pwm_d;
            data_sh_q   <= data_sh_d;
            dp_sh_q     <= dp_sh_d;
            en_sh_q     <= en_sh_d;
            lzb_sh_q    <= lzb_sh_d;
            pattern_q   <= pattern_d;
            digit_q     <= digit_d;
            frame_arm_q <= frame_arm_d;
            // Delayed one more cycle so the pulse lands after the last lit output.
            frame_q     <= frame_arm_q;
        end
    end

    assign bus.PATTERN = pattern_q;
    assign bus.DIGIT   = digit_q;
    assign bus.FRAME   = frame_q;

endmodule
